cp_insert: RTL and testbench

- Sits directly downstream of the transmitter IFFT stage in the DMT chain.
- Captures each 128-point IFFT output frame (real part only, under Hermitian symmetry) into a ping-pong buffer.
- Emits the frame with a cyclic prefix: the last CP_LEN samples first, then all N_FFT samples, over a valid/ready stream toward the DAC interface.
- Flags dropped and malformed frames.

---
 rtl/dmt_pkg.sv | 16 +
 rtl/cp_pingpong_ram.sv | 29 ++
 rtl/cp_insert.sv | 244 ++++++++++++++++++++++++
 tb/tb_cp_insert.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmt_pkg.sv
// Shared defaults and types for the DMT transmit chain.
// Holds the frame geometry and the cyclic-prefix reader state encoding.
package dmt_pkg;

   localparam int unsigned DATA_W = 28;
   localparam int unsigned N_FFT  = 128;
   localparam int unsigned IDX_W  = 7;
   localparam int unsigned CP_LEN = 32;

   typedef enum logic [1:0] {
      IDLE,
      PREFIX,
      BODY
   } rd_state_e;

endpackage

// File: rtl/cp_pingpong_ram.sv
// Two-bank sample store: one synchronous write port, one combinational read port.
// The bank select is the top address bit, so each bank holds one full frame.
module cp_pingpong_ram #(
   parameter int unsigned DATA_W = 28,
   parameter int unsigned IDX_W  = 7
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic              wbank_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              rbank_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** (IDX_W + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[{wbank_i, waddr_i}] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[{rbank_i, raddr_i}];

endmodule

// File: rtl/cp_insert.sv
// Captures IFFT frames into a ping-pong buffer and replays each one with a
// cyclic prefix (last CP_LEN samples first) over a valid/ready stream.
module cp_insert #(
   parameter int unsigned DATA_W = dmt_pkg::DATA_W,
   parameter int unsigned N_FFT  = dmt_pkg::N_FFT,
   parameter int unsigned IDX_W  = dmt_pkg::IDX_W,
   parameter int unsigned CP_LEN = dmt_pkg::CP_LEN
) (
   input  logic              SYS_CLK,
   input  logic              RST_N,
   input  logic [DATA_W-1:0] S_DATA_RE_IN,
   input  logic [IDX_W-1:0]  S_DATA_IN_INDEX,
   input  logic              S_DATA_VALID,
   input  logic              S_DATA_LAST,
   output logic [DATA_W-1:0] M_DATA_OUT,
   output logic              M_DATA_VALID,
   input  logic              M_DATA_READY,
   output logic              M_DATA_CP,
   output logic              M_DATA_FIRST,
   output logic              M_DATA_LAST,
   output logic              EVENT_OVERFLOW,
   output logic              EVENT_FRAME_ERR
);

   import dmt_pkg::*;

   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_FFT - 1);
   localparam logic [IDX_W-1:0] IDX_PEN  = IDX_W'(N_FFT - 2);
   localparam logic [IDX_W-1:0] CP_START = IDX_W'(N_FFT - CP_LEN);

   // Write side
   logic             wr_bank_q, wr_bank_d;
   logic [1:0]       full_q, full_d;
   logic             in_frame_q, in_frame_d;
   logic             drop_q, drop_d;
   logic [IDX_W-1:0] wcnt_q, wcnt_d;
   logic             ovf_q, ovf_d;
   logic             ferr_q, ferr_d;
   logic             we;
   logic             full_set;

   // Read side
   rd_state_e        state_q, state_d;
   logic             rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0] raddr_q, raddr_d;
   logic             valid_q, valid_d;
   logic             cp_q, cp_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic             rbank;
   logic             load;
   logic             full_clr;
   logic             adv;
   logic [DATA_W-1:0] rdata;

   cp_pingpong_ram #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_ram (
      .clk_i   (SYS_CLK),
      .we_i    (we),
      .wbank_i (wr_bank_q),
      .waddr_i (S_DATA_IN_INDEX),
      .wdata_i (S_DATA_RE_IN),
      .rbank_i (rbank),
      .raddr_i (raddr_d),
      .rdata_o (rdata)
   );

   // A frame is dropped only by its start sample; a malformed frame is
   // abandoned at the first bad sample and the rest ignored until LAST.
   always_comb begin
      wr_bank_d  = wr_bank_q;
      in_frame_d = in_frame_q;
      drop_d     = drop_q;
      wcnt_d     = wcnt_q;
      ovf_d      = 1'b0;
      ferr_d     = 1'b0;
      we         = 1'b0;
      full_set   = 1'b0;
      if (S_DATA_VALID) begin
         in_frame_d = ~S_DATA_LAST;
         if (!in_frame_q && full_q[wr_bank_q]) begin
            ovf_d  = 1'b1;
            drop_d = ~S_DATA_LAST;
            wcnt_d = '0;
         end else if (in_frame_q && drop_q) begin
            drop_d = ~S_DATA_LAST;
            wcnt_d = '0;
         end else begin
            we = 1'b1;
            if (S_DATA_LAST) begin
               wcnt_d = '0;
               if (wcnt_q == IDX_MAX) begin
                  full_set  = 1'b1;
                  wr_bank_d = ~wr_bank_q;
               end else begin
                  ferr_d = 1'b1;
               end
            end else if (wcnt_q == IDX_MAX) begin
               ferr_d = 1'b1;
               drop_d = 1'b1;
               wcnt_d = '0;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      full_d = full_q;
      if (full_set) full_d[wr_bank_q] = 1'b1;
      if (full_clr) full_d[rd_bank_q] = 1'b0;
   end

   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_bank_q  <= 1'b0;
         full_q     <= '0;
         in_frame_q <= 1'b0;
         drop_q     <= 1'b0;
         wcnt_q     <= '0;
         ovf_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         wr_bank_q  <= wr_bank_d;
         full_q     <= full_d;
         in_frame_q <= in_frame_d;
         drop_q     <= drop_d;
         wcnt_q     <= wcnt_d;
         ovf_q      <= ovf_d;
         ferr_q     <= ferr_d;
      end
   end

   assign adv = ~valid_q | M_DATA_READY;

   // The RAM is addressed with the next presented address so the sample lands
   // in the output register on the same edge the address advances.
   always_comb begin
      state_d   = state_q;
      rd_bank_d = rd_bank_q;
      raddr_d   = raddr_q;
      valid_d   = valid_q;
      cp_d      = cp_q;
      first_d   = first_q;
      last_d    = last_q;
      rbank     = rd_bank_q;
      load      = 1'b0;
      full_clr  = 1'b0;
      data_d    = data_q;
      unique case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q] && adv) begin
               load    = 1'b1;
               raddr_d = CP_START;
               valid_d = 1'b1;
               cp_d    = 1'b1;
               first_d = 1'b1;
               last_d  = 1'b0;
               state_d = PREFIX;
            end
         end
         PREFIX: begin
            if (adv) begin
               load    = 1'b1;
               first_d = 1'b0;
               last_d  = 1'b0;
               if (raddr_q == IDX_MAX) begin
                  raddr_d = '0;
                  cp_d    = 1'b0;
                  state_d = BODY;
               end else begin
                  raddr_d = raddr_q + 1'b1;
               end
            end
         end
         BODY: begin
            if (adv) begin
               if (raddr_q == IDX_MAX) begin
                  full_clr  = 1'b1;
                  rd_bank_d = ~rd_bank_q;
                  if (full_q[~rd_bank_q]) begin
                     load    = 1'b1;
                     rbank   = ~rd_bank_q;
                     raddr_d = CP_START;
                     cp_d    = 1'b1;
                     first_d = 1'b1;
                     last_d  = 1'b0;
                     state_d = PREFIX;
                  end else begin
                     raddr_d = '0;
                     valid_d = 1'b0;
                     cp_d    = 1'b0;
                     first_d = 1'b0;
                     last_d  = 1'b0;
                     data_d  = '0;
                     state_d = IDLE;
                  end
               end else begin
                  load    = 1'b1;
                  raddr_d = raddr_q + 1'b1;
                  last_d  = (raddr_q == IDX_PEN);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) data_d = rdata;
   end

   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         rd_bank_q <= 1'b0;
         raddr_q   <= '0;
         valid_q   <= 1'b0;
         cp_q      <= 1'b0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         rd_bank_q <= rd_bank_d;
         raddr_q   <= raddr_d;
         valid_q   <= valid_d;
         cp_q      <= cp_d;
         first_q   <= first_d;
         last_q    <= last_d;
         data_q    <= data_d;
      end
   end

   assign M_DATA_OUT      = data_q;
   assign M_DATA_VALID    = valid_q;
   assign M_DATA_CP       = cp_q;
   assign M_DATA_FIRST    = first_q;
   assign M_DATA_LAST     = last_q;
   assign EVENT_OVERFLOW  = ovf_q;
   assign EVENT_FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_cp_insert.sv
// Scoreboard bench for cp_insert: frames are modelled as index->value maps,
// and each accepted frame expands into its prefix+body symbol in a queue.
module tb_cp_insert;

   localparam int unsigned DW  = 28;
   localparam int unsigned N   = 128;
   localparam int unsigned CPL = 32;
   localparam int unsigned SYM = N + CPL;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_re;
   logic [6:0]    s_idx;
   logic          s_valid, s_last;
   logic [DW-1:0] m_out;
   logic          m_valid, m_ready, m_cp, m_first, m_last;
   logic          ev_ovf, ev_ferr;

   always #5 clk = ~clk;

   cp_insert #(
      .DATA_W (DW),
      .N_FFT  (N),
      .IDX_W  (7),
      .CP_LEN (CPL)
   ) dut (
      .SYS_CLK         (clk),
      .RST_N           (rst_n),
      .S_DATA_RE_IN    (s_re),
      .S_DATA_IN_INDEX (s_idx),
      .S_DATA_VALID    (s_valid),
      .S_DATA_LAST     (s_last),
      .M_DATA_OUT      (m_out),
      .M_DATA_VALID    (m_valid),
      .M_DATA_READY    (m_ready),
      .M_DATA_CP       (m_cp),
      .M_DATA_FIRST    (m_first),
      .M_DATA_LAST     (m_last),
      .EVENT_OVERFLOW  (ev_ovf),
      .EVENT_FRAME_ERR (ev_ferr)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          cp;
      logic          first;
      logic          last;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned tests = 0, fails = 0;
   int unsigned committed = 0, released = 0;
   int unsigned ovf_exp = 0, ferr_exp = 0, ovf_seen = 0, ferr_seen = 0;
   int unsigned acc_cnt = 0, valid_cnt = 0, run_len = 0, max_run = 0;
   int unsigned ready_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) step();
   endtask

   // Ready driver
   initial begin
      logic [3:0] pat;
      int unsigned cyc;
      pat = 4'b1001;
      cyc = 0;
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'b0;
            2: m_ready = pat[cyc % 4];
            default: m_ready = ($urandom_range(3, 0) != 0);
         endcase
         cyc++;
      end
   end

   // Monitor: pops the scoreboard on every accepted sample, checks stall stability.
   initial begin
      logic            hold;
      logic [DW+3:0]   snap;
      exp_t            e;
      hold = 1'b0;
      snap = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
            run_len = 0;
         end else begin
            if (ev_ovf)  ovf_seen++;
            if (ev_ferr) ferr_seen++;
            if (hold)
               check("stall_hold", {m_valid, m_out, m_cp, m_first, m_last}, snap);
            if (m_valid) begin
               valid_cnt++;
               run_len++;
               if (run_len > max_run) max_run = run_len;
            end else begin
               run_len = 0;
            end
            if (m_valid && m_ready) begin
               acc_cnt++;
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_output: got sample 0x%0h, expected none", m_out);
               end else begin
                  e = exp_q.pop_front();
                  check("sample", {m_out, m_cp, m_first, m_last}, {e.data, e.cp, e.first, e.last});
                  if (e.last) released++;
               end
            end
            hold = m_valid && !m_ready;
            snap = {1'b1, m_out, m_cp, m_first, m_last};
         end
      end
   end

   // Drives one frame of len samples; the model decides drop / error / accept
   // at the moment the start sample is driven.
   task automatic send_frame(input int unsigned len, input bit rnd,
                             input int unsigned offs, input bit shuf);
      logic [DW-1:0] mem [N];
      int unsigned   perm [N];
      logic [DW-1:0] v;
      bit            drop, good;
      exp_t          e;
      for (int unsigned i = 0; i < N; i++) perm[i] = i;
      if (shuf) begin
         for (int unsigned i = N - 1; i > 0; i--) begin
            int unsigned j, t;
            j = $urandom_range(i, 0);
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
         end
      end
      drop = (committed - released) >= 2;
      good = !drop && (len == N);
      if (drop) ovf_exp++;
      else if (len != N) ferr_exp++;
      for (int unsigned i = 0; i < len; i++) begin
         v = rnd ? DW'($urandom) : DW'(perm[i % N] + offs);
         if (i < N) mem[perm[i]] = v;
         s_valid = 1'b1;
         s_idx   = 7'(perm[i % N]);
         s_re    = v;
         s_last  = (i == len - 1);
         if (i == len - 1 && good) committed++;
         step();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (good) begin
         for (int unsigned k = 0; k < SYM; k++) begin
            e.data  = (k < CPL) ? mem[N - CPL + k] : mem[k - CPL];
            e.cp    = (k < CPL);
            e.first = (k == 0);
            e.last  = (k == SYM - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic wait_drain(input int unsigned budget);
      int unsigned n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int unsigned a0, v0, o0, n, len;
      s_re = '0; s_idx = '0; s_valid = 1'b0; s_last = 1'b0;
      idle(3);
      check("reset_outputs", {m_valid, m_out, m_cp, m_first, m_last, ev_ovf, ev_ferr}, 0);
      rst_n = 1'b1;
      idle(2);

      // Single frame, value = index; first valid two cycles after LAST
      send_frame(N, 1'b0, 0, 1'b0);
      check("latency_not_yet", m_valid, 0);
      step();
      check("latency_valid", m_valid, 1);
      check("latency_first_data", {m_out, m_cp, m_first}, {28'd96, 1'b1, 1'b1});
      wait_drain(400);
      idle(5);

      // Back-to-back frames A then B = index+1000, no output gap
      send_frame(N, 1'b0, 0, 1'b0);
      send_frame(N, 1'b0, 1000, 1'b0);
      wait_drain(600);
      idle(3);
      check("b2b_contiguous", max_run, 2 * SYM);

      // Three zero-gap frames with ready low: third one dropped
      ready_mode = 1;
      o0 = ovf_seen;
      send_frame(N, 1'b1, 0, 1'b1);
      send_frame(N, 1'b1, 0, 1'b1);
      send_frame(N, 1'b1, 0, 1'b1);
      idle(5);
      check("overflow_one_pulse", ovf_seen - o0, 1);
      check("overflow_model", ovf_seen, ovf_exp);
      a0 = acc_cnt;
      ready_mode = 0;
      wait_drain(800);
      idle(5);
      check("overflow_emitted", acc_cnt - a0, 2 * SYM);

      // Short frame (LAST at index 99), then a good one
      v0 = valid_cnt;
      send_frame(100, 1'b0, 0, 1'b0);
      idle(10);
      check("short_frame_err", ferr_seen, ferr_exp);
      check("short_frame_silent", valid_cnt - v0, 0);
      send_frame(N, 1'b1, 0, 1'b1);
      wait_drain(400);

      // Long frame (130 samples) also flagged once
      send_frame(130, 1'b1, 0, 1'b0);
      idle(10);
      check("long_frame_err", ferr_seen, ferr_exp);

      // Ready toggling 1,0,0,1
      ready_mode = 2;
      a0 = acc_cnt;
      send_frame(N, 1'b1, 0, 1'b1);
      wait_drain(800);
      idle(3);
      check("toggle_count", acc_cnt - a0, SYM);
      ready_mode = 0;

      // Reset for one cycle in the middle of a symbol
      a0 = acc_cnt;
      send_frame(N, 1'b1, 0, 1'b0);
      n = 0;
      while (acc_cnt - a0 < 50 && n < 400) begin
         step();
         n++;
      end
      check("reset_reached_50", (acc_cnt - a0) >= 50, 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {m_valid, m_out, m_cp, m_first, m_last}, 0);
      exp_q.delete();
      committed = released;
      step();
      rst_n = 1'b1;
      v0 = valid_cnt;
      idle(200);
      check("no_output_after_reset", valid_cnt - v0, 0);
      send_frame(N, 1'b1, 0, 1'b1);
      wait_drain(400);

      // Randomized traffic
      ready_mode = 3;
      for (int unsigned f = 0; f < 30; f++) begin
         n = $urandom_range(99, 0);
         if (n < 80)      len = N;
         else if (n < 90) len = $urandom_range(N - 1, 60);
         else             len = $urandom_range(140, N + 1);
         send_frame(len, 1'b1, 0, len == N);
         idle($urandom_range(60, 0));
      end
      ready_mode = 0;
      wait_drain(2000);
      idle(5);
      check("random_overflow_count", ovf_seen, ovf_exp);
      check("random_frame_err_count", ferr_seen, ferr_exp);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

endmodule
